// File: rtl/nds_bram_read.sv
// Frame reader: one AXI-lite style read per 18-bit RGB666 pixel, with prefetch FIFO and valid/ready pixel output.
// Optional NDS_BRAM_READ_RRESP_CHECK_EN makes rd_err latch any non-OKAY read response.
module nds_bram_read #(
  parameter int          FRAME_W    = 256,
  parameter int          FRAME_H    = 192,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_req,
  output logic        busy,
  output logic [31:0] S_AXI_ARADDR,
  output logic        S_AXI_ARVALID,
  input  logic        S_AXI_ARREADY,
  input  logic [31:0] S_AXI_RDATA,
  input  logic [1:0]  S_AXI_RRESP,
  input  logic        S_AXI_RVALID,
  output logic        S_AXI_RREADY,
  output logic [5:0]  red,
  output logic [5:0]  green,
  output logic [5:0]  blue,
  output logic        px_valid,
  input  logic        px_ready,
  output logic        px_sof,
  output logic        px_eol,
  output logic        rd_err
);

  localparam int                PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [15:0]       LAST_IDX = 16'(FRAME_W * FRAME_H - 1);
  localparam logic [15:0]       LAST_COL = 16'(FRAME_W - 1);
  localparam logic [PTR_W:0]    DEPTH_C  = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

  state_t           state;
  logic [15:0]      index;
  logic [15:0]      col;
  logic [19:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_next;
  logic             push;
  logic             pop;
  logic             has_room;
  logic [19:0]      wdata;

  assign push       = S_AXI_RREADY && S_AXI_RVALID;
  assign pop        = px_valid && px_ready;
  assign px_valid   = (count != '0);
  assign count_next = count + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
  // Room is judged after this cycle's push/pop so a new read always has a slot waiting.
  assign has_room   = (count_next < DEPTH_C);
  assign wdata      = {S_AXI_RDATA[17:0], (index == 16'd0), (col == LAST_COL)};
  assign {red, green, blue, px_sof, px_eol} = mem[rd_ptr];

  function automatic logic [31:0] addr_of(input logic [15:0] idx);
    return BASE_ADDR + {14'd0, idx, 2'b00};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      index         <= 16'd0;
      col           <= 16'd0;
      busy          <= 1'b0;
      S_AXI_ARADDR  <= 32'h0;
      S_AXI_ARVALID <= 1'b0;
      S_AXI_RREADY  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (frame_req && !busy) begin
            state         <= ADDR;
            index         <= 16'd0;
            col           <= 16'd0;
            busy          <= 1'b1;
            S_AXI_ARADDR  <= BASE_ADDR;
            S_AXI_ARVALID <= 1'b1;
          end else if (busy && pop && (count == (PTR_W + 1)'(1))) begin
            busy <= 1'b0;
          end
        end
        ADDR: begin
          if (S_AXI_ARREADY) begin
            S_AXI_ARVALID <= 1'b0;
            S_AXI_RREADY  <= 1'b1;
            state         <= DATA;
          end
        end
        DATA: begin
          if (S_AXI_RREADY) begin
            if (S_AXI_RVALID) begin
              S_AXI_RREADY <= 1'b0;
              index        <= index + 16'd1;
              col          <= (col == LAST_COL) ? 16'd0 : col + 16'd1;
              if (index == LAST_IDX) begin
                state <= IDLE;
              end else if (has_room) begin
                state         <= ADDR;
                S_AXI_ARADDR  <= addr_of(index + 16'd1);
                S_AXI_ARVALID <= 1'b1;
              end
            end
          end else if (has_room) begin
            // FIFO was full after the last beat; index already points at the next pixel
            state         <= ADDR;
            S_AXI_ARADDR  <= addr_of(index);
            S_AXI_ARVALID <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Prefetch FIFO storage and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 20'h0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
    end
  end

`ifdef NDS_BRAM_READ_RRESP_CHECK_EN
  // Sticky error on any accepted beat with a non-OKAY response
  always_ff @(posedge clk) begin
    if (reset) rd_err <= 1'b0;
    else if (push && (S_AXI_RRESP != 2'b00)) rd_err <= 1'b1;
  end
  logic unused_bits;
  assign unused_bits = ^S_AXI_RDATA[31:18];
`else
  assign rd_err = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{S_AXI_RDATA[31:18], S_AXI_RRESP};
`endif

endmodule

// File: doc/nds_bram_read.md
NDS_BRAM_READ -- requirements
Module: nds_bram_read

Interface
REQ-001 SHALL have parameter FRAME_W, default 256, pixels per line.
REQ-002 SHALL have parameter FRAME_H, default 192, lines per frame.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0, byte address of pixel 0.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, pixel prefetch FIFO entries (power of 2, >=2).
REQ-005 SHALL have ports: clk in 1 clock, the only clock; reset in 1 reset, synchronous and active-high.
REQ-006 SHALL have ports: frame_req in 1 start-of-frame request pulse; busy out 1 frame in progress.
REQ-007 SHALL have ports: S_AXI_ARADDR out 32 read address; S_AXI_ARVALID out 1; S_AXI_ARREADY in 1.
REQ-008 SHALL have ports: S_AXI_RDATA in 32; S_AXI_RRESP in 2; S_AXI_RVALID in 1; S_AXI_RREADY out 1.
REQ-009 SHALL have ports: red, green, blue out 6 each; px_valid out 1; px_ready in 1; px_sof out 1 first pixel of frame; px_eol out 1 last pixel of line.
REQ-010 SHALL have port rd_err out 1, sticky read-error flag (see Configuration).

Function
REQ-011 SHALL run a read FSM with states IDLE, ADDR, DATA.
REQ-012 IDLE -> ADDR on frame_req=1; SHALL load word index 0 and assert busy in the same edge.
REQ-013 SHALL ignore frame_req while busy=1.
REQ-014 In ADDR, SHALL enter only when FIFO free slots >= 1; SHALL drive S_AXI_ARADDR = BASE_ADDR + 4*index and S_AXI_ARVALID=1, holding both stable until S_AXI_ARREADY=1.
REQ-015 On AR handshake SHALL deassert S_AXI_ARVALID next cycle and go to DATA; at most one read outstanding.
REQ-016 In DATA, S_AXI_RREADY SHALL be 1; on RVALID&RREADY SHALL push {RDATA[17:12], RDATA[11:6], RDATA[5:0]} to FIFO and increment index.
REQ-017 After push: if index was FRAME_W*FRAME_H-1, SHALL go IDLE; else SHALL go ADDR when FIFO has a free slot, otherwise wait in DATA with RREADY=0.
REQ-018 S_AXI_RREADY SHALL be 0 outside DATA; RDATA[31:18] SHALL be ignored.
REQ-019 Pixel output SHALL be valid/ready: px_valid = FIFO not empty; pop on px_valid&px_ready; red/green/blue/px_sof/px_eol stable while px_valid&!px_ready.
REQ-020 px_sof SHALL be 1 only with pixel index 0; px_eol SHALL be 1 when (index mod FRAME_W) = FRAME_W-1; both tags stored in FIFO with the pixel.
REQ-021 FIFO full SHALL never drop data; simultaneous push and pop when full-minus-zero or empty SHALL both complete in the same cycle.
REQ-022 busy SHALL fall on the cycle after the last pixel is popped, not when the last read completes.
REQ-023 Index counter SHALL be 16 bits, cleared on each new frame, no wrap within a frame.

Reset
REQ-024 On reset=1 at clk edge: state IDLE, S_AXI_ARVALID=0, S_AXI_RREADY=0, S_AXI_ARADDR=0, FIFO empty, px_valid=0, busy=0, rd_err=0, index=0.
REQ-025 Reset mid-frame SHALL abandon the frame; any later RVALID beat SHALL be ignored until a new frame_req.

Configuration
REQ-026 Macro NDS_BRAM_READ_RRESP_CHECK_EN defined: rd_err SHALL set the cycle after an accepted R beat with S_AXI_RRESP != 2'b00 and hold until reset; pixel still pushed.
REQ-027 Macro undefined: S_AXI_RRESP SHALL be ignored and rd_err tied 0.

Verification
REQ-028 Bench SHALL cover: frame_req, ARREADY/RVALID always 1, px_ready=1 -> 49152 pixels, ARADDR 0..0x2FFFC step 4, px_sof on first only, px_eol on every 256th.
REQ-029 Bench SHALL cover: ARREADY delayed 3 cycles -> ARADDR/ARVALID stable for those cycles, single outstanding read.
REQ-030 Bench SHALL cover: px_ready=0 for 20 cycles -> exactly FIFO_DEPTH (4) pixels buffered, no further ARVALID, no data loss after release.
REQ-031 Bench SHALL cover: RDATA=32'hFFFC_0FC0 at index 0 -> red=0x00, green=0x3F, blue=0x00 (upper bits ignored).
REQ-032 Bench SHALL cover: reset asserted at index 1000 -> all outputs at reset values next cycle; next frame_req restarts at ARADDR=BASE_ADDR.
REQ-033 Bench SHALL cover: with NDS_BRAM_READ_RRESP_CHECK_EN, RRESP=2'b10 on beat 5 -> rd_err=1 from next cycle, frame completes; without macro rd_err stays 0.
